// File: rtl/drain_pkg.sv
// Shared types and default widths for the stack drain controller.
package drain_pkg;

    localparam int N_DEF  = 8;
    localparam int CW_DEF = 14;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        WAIT,
        HOLD,
        DONE
    } drain_state_e;

endpackage

// File: rtl/stack_drain_ctrl_if.sv
// Stack-side pop port and valid/ready output stream of the drain controller.
interface stack_drain_ctrl_if #(
    parameter int N = drain_pkg::N_DEF
);
    logic         stk_empty;
    logic [N-1:0] stk_data;
    logic         stk_pop;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (
        input  stk_empty,
        input  stk_data,
        output stk_pop,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        output stk_empty,
        output stk_data,
        input  stk_pop,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/stack_drain_ctrl_item_counter.sv
// Delivered-word counter with synchronous clear/increment and the drain limit compare.
module item_counter #(
    parameter int CW = drain_pkg::CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_inc,
    input  logic [CW-1:0] i_limit,
    output logic [CW-1:0] o_count,
    output logic          o_at_limit
);

    logic [CW-1:0] r_count;
    logic [CW-1:0] r_limit;
    logic [CW-1:0] w_count_inc;

    assign w_count_inc = r_count + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_limit <= '0;
        end else if (i_clr) begin
            r_count <= '0;
            r_limit <= i_limit;
        end else if (i_inc) begin
            r_count <= w_count_inc;
        end
    end

    // True when the handshake now in progress brings the count up to the limit.
    assign o_at_limit = (r_limit != '0) && (w_count_inc == r_limit);
    assign o_count    = r_count;

endmodule

// File: rtl/stack_drain_ctrl.sv
// Pops a LIFO stack until empty and streams each word out on valid/ready.
// Optional macro DRAIN_LIMIT_EN adds a limit port that can end the drain early.
//
// state | meaning
// IDLE  | waiting for start
// POP   | stk_pop issued for one cycle
// WAIT  | popped word captured into out_data
// HOLD  | out_valid high until the sink accepts
// DONE  | one-cycle done pulse
module stack_drain_ctrl
    import drain_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int CW = CW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
`ifdef DRAIN_LIMIT_EN
    input  logic [CW-1:0]       limit,
`endif
    stack_drain_ctrl_if.master  bus,
    output logic                busy,
    output logic                done,
    output logic [CW-1:0]       count
);

    drain_state_e  r_state;
    drain_state_e  w_next;
    logic [N-1:0]  r_out_data;
    logic          w_clr;
    logic          w_inc;
    logic          w_at_limit;
    logic [CW-1:0] w_limit;

`ifdef DRAIN_LIMIT_EN
    assign w_limit = limit;
`else
    assign w_limit = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_out_data <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == WAIT) begin
                r_out_data <= bus.stk_data;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        bus.stk_pop   = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        w_clr         = 1'b0;
        w_inc         = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_clr  = 1'b1;
                    w_next = bus.stk_empty ? DONE : POP;
                end
            end
            POP: begin
                bus.stk_pop = 1'b1;
                w_next      = WAIT;
            end
            WAIT: w_next = HOLD;
            HOLD: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_inc  = 1'b1;
                    w_next = (bus.stk_empty || w_at_limit) ? DONE : POP;
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.out_data = r_out_data;

    item_counter #(.CW(CW)) u_item_counter (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_clr),
        .i_inc      (w_inc),
        .i_limit    (w_limit),
        .o_count    (count),
        .o_at_limit (w_at_limit)
    );

endmodule

// File: tb/tb_stack_drain_ctrl.sv
// Randomized bench: stack model plus a reverse-order scoreboard for stack_drain_ctrl.
module tb_stack_drain_ctrl;
    import drain_pkg::*;

    localparam int N  = N_DEF;
    localparam int CW = CW_DEF;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;
`ifdef DRAIN_LIMIT_EN
    logic [CW-1:0] lim = '0;
`endif

    stack_drain_ctrl_if #(.N(N)) bus ();

    stack_drain_ctrl #(.N(N), .CW(CW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef DRAIN_LIMIT_EN
        .limit (lim),
`endif
        .bus   (bus.master),
        .busy  (busy),
        .done  (done),
        .count (count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Physical stack the DUT drains; data appears the cycle after a pop.
    logic [N-1:0] mem [0:63];
    int           sp = 0;
    logic         push_en = 1'b0;
    logic [N-1:0] push_val = '0;

    assign bus.stk_empty = (sp == 0);

    always @(posedge clk) begin
        if (bus.stk_pop && sp > 0) begin
            bus.stk_data <= mem[sp-1];
            sp           <= sp - 1;
        end else if (push_en) begin
            mem[sp] <= push_val;
            sp      <= sp + 1;
        end
    end

    // Reference contents: back of the queue is the top of the stack.
    logic [N-1:0] model_q[$];

    task automatic push_word(input logic [N-1:0] v);
        push_en  = 1'b1;
        push_val = v;
        @(negedge clk);
        push_en  = 1'b0;
        model_q.push_back(v);
    endtask

    // ready_mode: 0 = always ready, 1 = random, 2 = stall first word 5 cycles
    task automatic run_drain(input int limit, input int ready_mode, input bit restart);
        logic [N-1:0] exp_seq[$];
        int     n_exp;
        int     idx = 0;
        int     pops = 0;
        int     first_v = -1;
        int     last_hs = 0;
        int     stall = 0;
        bit     got_done = 0;
        bit     prev_v = 0;
        bit     prev_hs = 0;
        bit     prev_pop = 0;
        bit     hs;
        logic [N-1:0] prev_d = '0;

        for (int i = model_q.size() - 1; i >= 0; i--) exp_seq.push_back(model_q[i]);
        n_exp = exp_seq.size();
        if (limit != 0 && limit < n_exp) n_exp = limit;
`ifdef DRAIN_LIMIT_EN
        lim = CW'(limit);
`endif
        bus.out_ready = (ready_mode == 0);
        start = 1'b1;
        for (int k = 1; k <= 300 && !got_done; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (restart && prev_pop) start = 1'b1;
            chk("busy", busy, 1);
            if (bus.stk_pop) begin
                pops++;
                chk("pop_nonempty", bus.stk_empty, 0);
            end
            if (bus.out_valid) begin
                if (first_v < 0) first_v = k;
                if (prev_v && !prev_hs) chk("data_stable", bus.out_data, prev_d);
                chk("pops_in_hold", pops, idx + 1);
            end
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = (stall >= 5);
            endcase
            if (bus.out_valid) stall++;
            hs = bus.out_valid && bus.out_ready;
            if (hs) begin
                if (idx < n_exp) chk("data", bus.out_data, exp_seq[idx]);
                else chk("extra_word", idx + 1, n_exp);
                idx++;
                last_hs = k;
            end
            if (done) begin
                got_done = 1;
                chk("done_timing", k, (n_exp == 0) ? 1 : last_hs + 1);
                chk("count", count, n_exp);
                chk("words", idx, n_exp);
                chk("pops", pops, n_exp);
            end
            prev_v   = bus.out_valid;
            prev_d   = bus.out_data;
            prev_hs  = hs;
            prev_pop = bus.stk_pop;
        end
        start = 1'b0;
        if (!got_done) chk("done_seen", 0, 1);
        if (n_exp == 0) chk("no_valid", first_v, -1);
        else chk("first_latency", first_v, 3);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("count_hold", count, n_exp);
        repeat (n_exp) void'(model_q.pop_back());
        chk("remaining", sp, model_q.size());
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int pops;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_pop", bus.stk_pop, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_data", bus.out_data, 0);
        rst = 1'b1;
        @(negedge clk);

        // empty stack
        run_drain(0, 0, 0);

        // ordering
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        run_drain(0, 0, 0);

        // backpressure
        for (int i = 0; i < 3; i++) push_word(N'($urandom));
        run_drain(0, 2, 0);

        // start pulsed during WAIT
        for (int i = 0; i < 3; i++) push_word(N'($urandom));
        run_drain(0, 0, 1);

        // reset while HOLD
        for (int i = 0; i < 3; i++) push_word(N'($urandom));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 10 && !bus.out_valid; k++) @(negedge clk);
        chk("rst_reach_hold", bus.out_valid, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_pop", bus.stk_pop, 0);
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_count", count, 0);
        @(negedge clk);
        rst = 1'b1;
        pops = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.stk_pop) pops++;
        end
        chk("rst_no_pop", pops, 0);
        chk("rst_stack_left", sp, 2);
        void'(model_q.pop_back());
        run_drain(0, 1, 0);

        // random drains
        for (int t = 0; t < 6; t++) begin
            int n = $urandom_range(0, 8);
            for (int i = 0; i < n; i++) push_word(N'($urandom));
            run_drain(0, 1, 0);
        end

`ifdef DRAIN_LIMIT_EN
        for (int i = 0; i < 5; i++) push_word(N'($urandom));
        run_drain(2, 0, 0);
        chk("limit_not_empty", bus.stk_empty, 0);
        chk("limit_left", sp, 3);
        run_drain(0, 1, 0);
        for (int i = 0; i < 6; i++) push_word(N'($urandom));
        run_drain($urandom_range(1, 8), 1, 0);
        run_drain(0, 0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
